// File: rtl/piso_shift_if.sv
// -----------------------------------------------------------------------------
// piso_shift_if
//   Bundle of the word-load handshake and the serial output stream of
//   piso_shift. clk and rst are not part of the bundle.
//
//   Handshake (valid/ready): a word moves on a rising clk edge where both
//   load_valid and load_ready are high. The producer holds load_valid and
//   data_in stable until that edge. load_ready may rise or fall without
//   regard to load_valid. data_in is only sampled on the accepting edge.
//
//   Signals
//     data_in      master -> slave  WIDTH  parallel word
//     load_valid   master -> slave  1      word on data_in is offered
//     load_ready   slave  -> master 1      word can be taken this cycle
//     serial_out   slave  -> master 1      serial bit stream
//     bit_valid    slave  -> master 1      serial_out carries a data bit
//     frame_start  slave  -> master 1      first bit of a word is showing
//     frame_done   slave  -> master 1      last bit of a word is showing
//     busy         slave  -> master 1      shifter is in its SHIFT state
//
//   Modports
//     master : the word producer / stream consumer side
//     slave  : the piso_shift block
// -----------------------------------------------------------------------------
interface piso_shift_if #(
    parameter int WIDTH = 4
);

    logic [WIDTH-1:0] data_in;
    logic             load_valid;
    logic             load_ready;
    logic             serial_out;
    logic             bit_valid;
    logic             frame_start;
    logic             frame_done;
    logic             busy;

    modport master (
        output data_in,
        output load_valid,
        input  load_ready,
        input  serial_out,
        input  bit_valid,
        input  frame_start,
        input  frame_done,
        input  busy
    );

    modport slave (
        input  data_in,
        input  load_valid,
        output load_ready,
        output serial_out,
        output bit_valid,
        output frame_start,
        output frame_done,
        output busy
    );

endinterface

// File: rtl/piso_shift.sv
// -----------------------------------------------------------------------------
// piso_shift
//   Parallel-in serial-out shifter. Takes a WIDTH-bit word through a
//   valid/ready handshake and emits it one bit per clk on serial_out,
//   flagging the first and last bit of every word. A new word can be taken
//   while the last bit of the previous one is showing, so words stream out
//   back to back without an idle cycle.
//
//   Parameters
//     WIDTH       word length in bits (>= 1)
//     MSB_FIRST   1: data_in[WIDTH-1] leaves first; 0: data_in[0] first
//     IDLE_LEVEL  level held on serial_out while no bit is being sent
//
//   Ports
//     clk   in  rising-edge clock
//     rst   in  asynchronous, active-high reset (discards a partial word)
//     bus   piso_shift_if.slave
//             data_in, load_valid         in
//             load_ready                  out (combinational from state)
//             serial_out, bit_valid,
//             frame_start, frame_done     out (registered)
//             busy                        out (decode of the state register)
// -----------------------------------------------------------------------------
module piso_shift #(
    parameter int WIDTH      = 4,
    parameter bit MSB_FIRST  = 1'b1,
    parameter bit IDLE_LEVEL = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    piso_shift_if.slave bus
);

    // Counter of bits still to come after the one currently on serial_out.
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] shreg;
    logic [CW-1:0]    bitcnt;

    logic             serial_q;
    logic             bit_valid_q;
    logic             frame_start_q;
    logic             frame_done_q;

    logic             load_ready;
    logic             accept;

    // Bit that leaves first from a freshly loaded word, and what remains.
    logic             load_bit;
    logic [WIDTH-1:0] load_rest;
    // Next bit taken from the shift register, and what remains after it.
    logic             next_bit;
    logic [WIDTH-1:0] shift_rest;

    // -------------------------------------------------------------------------
    // Handshake. A word can be taken from IDLE, or while the final bit of the
    // current word is on serial_out; that second case is what closes the gap
    // between consecutive words.
    // -------------------------------------------------------------------------
    always_comb begin
        load_ready = (state == IDLE) || ((state == SHIFT) && (bitcnt == '0));
        accept     = bus.load_valid && load_ready;
    end

    // -------------------------------------------------------------------------
    // Bit selection. The shift register always keeps the next bit to send at
    // the "outgoing" end, so the register moves toward the MSB for MSB-first
    // and toward the LSB for LSB-first. Vacated positions fill with zero.
    // -------------------------------------------------------------------------
    always_comb begin
        load_bit   = 1'b0;
        load_rest  = '0;
        next_bit   = 1'b0;
        shift_rest = '0;
        if (MSB_FIRST) begin
            load_bit   = bus.data_in[WIDTH-1];
            load_rest  = bus.data_in << 1;
            next_bit   = shreg[WIDTH-1];
            shift_rest = shreg << 1;
        end else begin
            load_bit   = bus.data_in[0];
            load_rest  = bus.data_in >> 1;
            next_bit   = shreg[0];
            shift_rest = shreg >> 1;
        end
    end

    // -------------------------------------------------------------------------
    // Control FSM and registered stream outputs.
    //   accept              : launch the first bit of the new word
    //   SHIFT, bitcnt > 0   : launch the next bit
    //   SHIFT, bitcnt == 0  : last bit has had its cycle, return to IDLE
    // load_ready is low in SHIFT with bitcnt > 0, so accept never collides
    // with a mid-word shift.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            shreg         <= '0;
            bitcnt        <= '0;
            serial_q      <= IDLE_LEVEL;
            bit_valid_q   <= 1'b0;
            frame_start_q <= 1'b0;
            frame_done_q  <= 1'b0;
        end else if (accept) begin
            state         <= SHIFT;
            shreg         <= load_rest;
            bitcnt        <= CW'(WIDTH - 1);
            serial_q      <= load_bit;
            bit_valid_q   <= 1'b1;
            frame_start_q <= 1'b1;
            // A one-bit word starts and ends on the same cycle.
            frame_done_q  <= (WIDTH == 1);
        end else if (state == SHIFT) begin
            if (bitcnt != '0) begin
                shreg         <= shift_rest;
                bitcnt        <= bitcnt - CW'(1);
                serial_q      <= next_bit;
                bit_valid_q   <= 1'b1;
                frame_start_q <= 1'b0;
                frame_done_q  <= (bitcnt == CW'(1));
            end else begin
                state         <= IDLE;
                serial_q      <= IDLE_LEVEL;
                bit_valid_q   <= 1'b0;
                frame_start_q <= 1'b0;
                frame_done_q  <= 1'b0;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign bus.load_ready  = load_ready;
    assign bus.serial_out  = serial_q;
    assign bus.bit_valid   = bit_valid_q;
    assign bus.frame_start = frame_start_q;
    assign bus.frame_done  = frame_done_q;
    assign bus.busy        = (state == SHIFT);

endmodule

// File: tb/tb_piso_shift.sv
// -----------------------------------------------------------------------------
// tb_piso_shift
//   Directed bench for piso_shift. Three instances share clk and rst:
//     u_a : WIDTH=4, MSB first, idle level 0
//     u_b : WIDTH=4, LSB first, idle level 1
//     u_c : WIDTH=1
//   Inputs change and outputs are sampled 1 time unit after a rising edge.
//   Output groups are compared as {serial_out, bit_valid, frame_start,
//   frame_done, busy}.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_piso_shift;

    logic clk;
    logic rst;

    int checks = 0;
    int errors = 0;

    piso_shift_if #(.WIDTH(4)) bus_a ();
    piso_shift_if #(.WIDTH(4)) bus_b ();
    piso_shift_if #(.WIDTH(1)) bus_c ();

    piso_shift #(.WIDTH(4), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) u_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a)
    );

    piso_shift #(.WIDTH(4), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b1)) u_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b)
    );

    piso_shift #(.WIDTH(1), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) u_c (
        .clk (clk),
        .rst (rst),
        .bus (bus_c)
    );

    // ---------------------------------------------------------------- clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------------------------------------------------------- helpers
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [4:0] outs_a();
        return {bus_a.serial_out, bus_a.bit_valid, bus_a.frame_start, bus_a.frame_done, bus_a.busy};
    endfunction

    function automatic logic [4:0] outs_b();
        return {bus_b.serial_out, bus_b.bit_valid, bus_b.frame_start, bus_b.frame_done, bus_b.busy};
    endfunction

    function automatic logic [4:0] outs_c();
        return {bus_c.serial_out, bus_c.bit_valid, bus_c.frame_start, bus_c.frame_done, bus_c.busy};
    endfunction

    // ---------------------------------------------------------------- stimulus
    initial begin
        logic [3:0] w;
        logic [7:0] stream;

        rst              = 1'b0;
        bus_a.load_valid = 1'b0;
        bus_a.data_in    = '0;
        bus_b.load_valid = 1'b0;
        bus_b.data_in    = '0;
        bus_c.load_valid = 1'b0;
        bus_c.data_in    = '0;

        // 1. Reset asserted mid-cycle: outputs idle right away.
        #3 rst = 1'b1;
        #1;
        chk("rst_a_outs", outs_a(), 5'b00000);
        chk("rst_b_outs", outs_b(), 5'b10000);
        chk("rst_c_outs", outs_c(), 5'b00000);
        step();
        step();
        rst = 1'b0;
        step();
        chk("post_rst_a_outs", outs_a(), 5'b00000);
        chk("post_rst_a_ready", bus_a.load_ready, 1);
        chk("post_rst_b_ready", bus_b.load_ready, 1);
        chk("post_rst_c_ready", bus_c.load_ready, 1);

        // 2. Single word 1001, MSB first.
        w = 4'b1001;
        bus_a.data_in    = w;
        bus_a.load_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            if (i == 0) bus_a.load_valid = 1'b0;
            chk($sformatf("single_outs_%0d", i), outs_a(),
                {w[3-i], 1'b1, (i == 0), (i == 3), 1'b1});
            chk($sformatf("single_ready_%0d", i), bus_a.load_ready, (i == 3));
        end
        step();
        chk("single_idle_outs", outs_a(), 5'b00000);
        chk("single_idle_ready", bus_a.load_ready, 1);

        // 3. Back-to-back A then 5 with load_valid held high.
        stream = 8'b1010_0101;
        bus_a.data_in    = 4'hA;
        bus_a.load_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            if (i == 0) bus_a.data_in = 4'h5;
            chk($sformatf("b2b_outs_%0d", i), outs_a(),
                {stream[7-i], 1'b1, (i == 0 || i == 4), (i == 3 || i == 7), 1'b1});
            if (i < 7) chk($sformatf("b2b_ready_%0d", i), bus_a.load_ready, (i == 3));
            if (i == 4) bus_a.load_valid = 1'b0;
        end
        step();
        chk("b2b_idle_outs", outs_a(), 5'b00000);

        // 4. Word 0 in flight; F offered from bit 2, data_in disturbed later.
        stream = 8'b0000_1111;
        bus_a.data_in    = 4'h0;
        bus_a.load_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            if (i == 0) bus_a.load_valid = 1'b0;
            if (i == 1) begin
                bus_a.load_valid = 1'b1;
                bus_a.data_in    = 4'hF;
            end
            chk($sformatf("hold_outs_%0d", i), outs_a(),
                {stream[7-i], 1'b1, (i == 0 || i == 4), (i == 3 || i == 7), 1'b1});
            chk($sformatf("hold_ready_%0d", i), bus_a.load_ready, (i == 3 || i == 7));
            if (i == 4) begin
                bus_a.load_valid = 1'b0;
                bus_a.data_in    = 4'h3;
            end
        end
        step();
        chk("hold_idle_outs", outs_a(), 5'b00000);

        // 5. Reset pulse during bit 3 of 1101, then a clean 0110.
        bus_a.data_in    = 4'b1101;
        bus_a.load_valid = 1'b1;
        step();
        bus_a.load_valid = 1'b0;
        chk("rstmid_bit1", outs_a(), 5'b11101);
        step();
        chk("rstmid_bit2", outs_a(), 5'b11001);
        step();
        chk("rstmid_bit3", outs_a(), 5'b01001);
        #2 rst = 1'b1;
        #1;
        chk("rstmid_outs", outs_a(), 5'b00000);
        rst = 1'b0;
        chk("rstmid_ready", bus_a.load_ready, 1);
        w = 4'b0110;
        bus_a.data_in    = w;
        bus_a.load_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            if (i == 0) bus_a.load_valid = 1'b0;
            chk($sformatf("after_rst_outs_%0d", i), outs_a(),
                {w[3-i], 1'b1, (i == 0), (i == 3), 1'b1});
        end
        step();
        chk("after_rst_idle", outs_a(), 5'b00000);

        // 6a. LSB first, 0001 -> 1,0,0,0; idle level 1 afterwards.
        w = 4'b0001;
        bus_b.data_in    = w;
        bus_b.load_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            if (i == 0) bus_b.load_valid = 1'b0;
            chk($sformatf("lsb_outs_%0d", i), outs_b(),
                {w[i], 1'b1, (i == 0), (i == 3), 1'b1});
        end
        step();
        chk("lsb_idle_outs", outs_b(), 5'b10000);

        // 6b. One-bit words: 1 then 0 back to back.
        bus_c.data_in    = 1'b1;
        bus_c.load_valid = 1'b1;
        step();
        bus_c.data_in = 1'b0;
        chk("w1_first_outs", outs_c(), 5'b11111);
        chk("w1_first_ready", bus_c.load_ready, 1);
        step();
        bus_c.load_valid = 1'b0;
        chk("w1_second_outs", outs_c(), 5'b01111);
        step();
        chk("w1_idle_outs", outs_c(), 5'b00000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
